// File: rtl/led_pwm_fader_multi.sv
// Multi-channel open-drain LED PWM driver with off/static/fade/blink modes per channel.
// Define GAMMA_CORRECT_EN to apply square-law brightness correction before the PWM compare.
module led_pwm_fader_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 250_000,
  parameter int unsigned BLINK_TICKS = 50,
  localparam int unsigned CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we_i,
  input  logic [CHW-1:0]      cfg_ch_i,
  input  logic [1:0]          cfg_mode_i,
  input  logic [PWM_BITS-1:0] cfg_level_i,
  output logic                pwm_sync_o,
  output wire  [NUM_CH-1:0]   led_o
);

  typedef enum logic [1:0] {
    ModeOff    = 2'd0,
    ModeStatic = 2'd1,
    ModeFade   = 2'd2,
    ModeBlink  = 2'd3
  } mode_e;

  localparam int unsigned SCW = $clog2(STEP_CYCLES);
  localparam int unsigned BCW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PWM_BITS-1:0] PwmLast   = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [PWM_BITS-1:0] FullOn    = {PWM_BITS{1'b1}};
  localparam logic [SCW-1:0]      StepLast  = SCW'(STEP_CYCLES - 1);
  localparam logic [BCW-1:0]      BlinkLast = BCW'(BLINK_TICKS - 1);
  localparam logic [CHW:0]        NumChW    = (CHW + 1)'(NUM_CH);

  function automatic logic [PWM_BITS-1:0] eff(input logic [PWM_BITS-1:0] b);
`ifdef GAMMA_CORRECT_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = (2 * PWM_BITS)'(b) * (2 * PWM_BITS)'(b);
    if (b == FullOn) begin
      return FullOn;
    end else if (b < PWM_BITS'(2 ** (PWM_BITS / 2))) begin
      return '0;
    end else begin
      return sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    return b;
`endif
  endfunction

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_sync_q, pwm_sync_d;
  logic                pwm_wrap;
  logic [SCW-1:0]      step_cnt_q, step_cnt_d;
  logic                tick;
  logic                cfg_ok;

  mode_e                             mode_q [NUM_CH];
  mode_e                             mode_d [NUM_CH];
  logic [NUM_CH-1:0][PWM_BITS-1:0]   level_q, level_d;
  logic [NUM_CH-1:0][PWM_BITS-1:0]   bright_q, bright_d;
  logic [NUM_CH-1:0][PWM_BITS-1:0]   duty_q, duty_d;
  logic [NUM_CH-1:0][BCW-1:0]        blink_cnt_q, blink_cnt_d;
  logic [NUM_CH-1:0]                 dir_q, dir_d;  // 1 = fading down
  logic [NUM_CH-1:0]                 blink_ph_q, blink_ph_d;
  logic [NUM_CH-1:0]                 led_on_q, led_on_d;

  always_comb begin
    pwm_wrap   = (pwm_cnt_q == PwmLast);
    pwm_cnt_d  = pwm_wrap ? '0 : pwm_cnt_q + PWM_BITS'(1);
    pwm_sync_d = pwm_wrap;
    tick       = (step_cnt_q == StepLast);
    step_cnt_d = tick ? '0 : step_cnt_q + SCW'(1);
    cfg_ok     = cfg_we_i && ({1'b0, cfg_ch_i} < NumChW);
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      mode_d[c]      = mode_q[c];
      level_d[c]     = level_q[c];
      bright_d[c]    = bright_q[c];
      dir_d[c]       = dir_q[c];
      blink_cnt_d[c] = blink_cnt_q[c];
      blink_ph_d[c]  = blink_ph_q[c];

      // A write restarts the channel and swallows a coincident tick for it.
      if (cfg_ok && (cfg_ch_i == CHW'(c))) begin
        mode_d[c]      = mode_e'(cfg_mode_i);
        level_d[c]     = cfg_level_i;
        bright_d[c]    = '0;
        dir_d[c]       = 1'b0;
        blink_cnt_d[c] = '0;
        blink_ph_d[c]  = 1'b0;
      end else begin
        case (mode_q[c])
          ModeOff:    bright_d[c] = '0;
          ModeStatic: bright_d[c] = level_q[c];
          ModeFade: begin
            if (tick) begin
              if (!dir_q[c]) begin
                if (bright_q[c] >= level_q[c]) begin
                  dir_d[c]    = 1'b1;
                  bright_d[c] = level_q[c];
                end else begin
                  bright_d[c] = bright_q[c] + PWM_BITS'(1);
                end
              end else if (bright_q[c] == '0) begin
                dir_d[c] = 1'b0;
              end else begin
                bright_d[c] = bright_q[c] - PWM_BITS'(1);
              end
            end
          end
          ModeBlink: begin
            if (tick) begin
              if (blink_cnt_q[c] == BlinkLast) begin
                blink_cnt_d[c] = '0;
                blink_ph_d[c]  = ~blink_ph_q[c];
              end else begin
                blink_cnt_d[c] = blink_cnt_q[c] + BCW'(1);
              end
              bright_d[c] = blink_ph_d[c] ? level_q[c] : '0;
            end
          end
          default: bright_d[c] = '0;
        endcase
      end

      // Duty only reloads at the period boundary so no partial periods are emitted.
      duty_d[c]   = pwm_wrap ? eff(bright_q[c]) : duty_q[c];
      led_on_d[c] = (pwm_cnt_q < duty_q[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q   <= '0;
      pwm_sync_q  <= 1'b0;
      step_cnt_q  <= '0;
      level_q     <= '0;
      bright_q    <= '0;
      duty_q      <= '0;
      blink_cnt_q <= '0;
      dir_q       <= '0;
      blink_ph_q  <= '0;
      led_on_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        mode_q[c] <= ModeOff;
      end
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      pwm_sync_q  <= pwm_sync_d;
      step_cnt_q  <= step_cnt_d;
      level_q     <= level_d;
      bright_q    <= bright_d;
      duty_q      <= duty_d;
      blink_cnt_q <= blink_cnt_d;
      dir_q       <= dir_d;
      blink_ph_q  <= blink_ph_d;
      led_on_q    <= led_on_d;
      for (int c = 0; c < NUM_CH; c++) begin
        mode_q[c] <= mode_d[c];
      end
    end
  end

  assign pwm_sync_o = pwm_sync_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_led
    assign led_o[g] = led_on_q[g] ? 1'b0 : 1'bz;
  end

endmodule

// File: tb/tb_led_pwm_fader_multi.sv
// Directed bench for led_pwm_fader_multi; open-drain pins are pulled up so off reads as 1.
module tb_led_pwm_fader_multi;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_level;
  logic       pwm_sync;
  wire  [3:0] led;

  logic       cfg_we5;
  logic [2:0] cfg_ch5;
  logic [1:0] cfg_mode5;
  logic [3:0] cfg_level5;
  logic       sync5;
  wire  [4:0] led5;

  int total = 0;
  int bad   = 0;

`ifdef GAMMA_CORRECT_EN
  localparam int G8 = 4;
  localparam int G3 = 0;
`else
  localparam int G8 = 8;
  localparam int G3 = 3;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_pu
    pullup pu (led[g]);
  end
  for (genvar g = 0; g < 5; g++) begin : g_pu5
    pullup pu (led5[g]);
  end

  led_pwm_fader_multi #(
    .NUM_CH(4), .PWM_BITS(4), .STEP_CYCLES(4), .BLINK_TICKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_mode_i(cfg_mode),
    .cfg_level_i(cfg_level), .pwm_sync_o(pwm_sync), .led_o(led)
  );

  led_pwm_fader_multi #(
    .NUM_CH(5), .PWM_BITS(4), .STEP_CYCLES(4), .BLINK_TICKS(2)
  ) dut5 (
    .clk(clk), .rst_n(rst_n), .cfg_we_i(cfg_we5), .cfg_ch_i(cfg_ch5), .cfg_mode_i(cfg_mode5),
    .cfg_level_i(cfg_level5), .pwm_sync_o(sync5), .led_o(led5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Duty of ch0 may only move in the cycle that pwm_sync is high.
  logic       mon_en = 1'b0;
  logic [3:0] duty_prev = '0;
  int         dchg_bad = 0;
  int         dchg_seen = 0;
  always @(negedge clk) begin
    if (mon_en && (dut.duty_q[0] !== duty_prev)) begin
      if (pwm_sync !== 1'b1) dchg_bad <= dchg_bad + 1;
      else                   dchg_seen <= dchg_seen + 1;
    end
    duty_prev <= dut.duty_q[0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] lvl);
    cfg_ch = ch; cfg_mode = mode; cfg_level = lvl; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wr5(input logic [2:0] ch, input logic [1:0] mode, input logic [3:0] lvl);
    cfg_ch5 = ch; cfg_mode5 = mode; cfg_level5 = lvl; cfg_we5 = 1'b1;
    @(negedge clk);
    cfg_we5 = 1'b0;
  endtask

  // Counts low cycles of one full PWM period, allowing for the 1-cycle output latency.
  task automatic measure(input bit use5, input int ch, output int n);
    int k = 0;
    n = 0;
    while (((use5 ? sync5 : pwm_sync) !== 1'b1) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check("sync_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if ((use5 ? led5[ch] : led[ch]) === 1'b0) n++;
    end
  endtask

  task automatic wait_tick(input bit advance);
    int k = 0;
    while (dut.tick !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check("tick_timeout", 32'd0, 32'd1);
    if (advance) @(negedge clk);
  endtask

  int n;
  int k;
  int fade_exp [9]  = '{1, 2, 3, 3, 2, 1, 0, 0, 1};
  int blink_exp [7] = '{0, 8, 8, 0, 0, 8, 8};

  initial begin
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_level = '0;
    cfg_we5 = 1'b0; cfg_ch5 = '0; cfg_mode5 = '0; cfg_level5 = '0;
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led), 32'hF);
    check("reset_sync", 32'(pwm_sync), 32'd0);
    rst_n = 1'b1;

    // PWM period
    k = 0;
    while (pwm_sync !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    k = 0;
    do begin @(negedge clk); k++; end while (pwm_sync !== 1'b1 && k < 40);
    check("sync_period", k, 15);

    // STATIC
    wr(2'd1, 2'd1, 4'd15);
    measure(1'b0, 1, n);
    measure(1'b0, 1, n);
    check("static15_p2", n, 15);
    measure(1'b0, 1, n);
    check("static15_p3", n, 15);
    measure(1'b0, 0, n);
    check("ch0_off", n, 0);
    wr(2'd1, 2'd1, 4'd5);
    measure(1'b0, 1, n);
    measure(1'b0, 1, n);
    check("static5", n, 5);
    wr(2'd1, 2'd1, 4'd0);
    measure(1'b0, 1, n);
    measure(1'b0, 1, n);
    check("static0", n, 0);
    wr(2'd1, 2'd1, 4'd15);

    // FADE ch0 level 3
    mon_en = 1'b1;
    wr(2'd0, 2'd2, 4'd3);
    for (int i = 0; i < 9; i++) begin
      wait_tick(1'b1);
      check($sformatf("fade_tick%0d", i + 1), 32'(dut.bright_q[0]), fade_exp[i]);
    end

    // Write coincident with a tick: ch0 restarts, ch3 still steps
    wr(2'd3, 2'd2, 4'd15);
    wait_tick(1'b1);
    check("ch3_tick1", 32'(dut.bright_q[3]), 32'd1);
    wait_tick(1'b0);
    wr(2'd0, 2'd2, 4'd3);
    check("tickwr_ch0", 32'(dut.bright_q[0]), 32'd0);
    check("tickwr_ch3", 32'(dut.bright_q[3]), 32'd2);
    wait_tick(1'b1);
    check("tickwr_ch0_next", 32'(dut.bright_q[0]), 32'd1);
    mon_en = 1'b0;
    check("duty_glitch", dchg_bad, 0);
    check("duty_changed", 32'(dchg_seen > 0), 32'd1);

    // Asynchronous reset while fading
    check("pre_reset_led1", 32'(led[1]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_led", 32'(led), 32'hF);
    check("async_reset_sync", 32'(pwm_sync), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (led !== 4'hF) k++;
    end
    check("post_reset_off", k, 0);

    // BLINK ch2 level 8 alongside static ch1
    wr(2'd1, 2'd1, 4'd15);
    wr(2'd2, 2'd3, 4'd8);
    for (int i = 0; i < 7; i++) begin
      wait_tick(1'b1);
      check($sformatf("blink_tick%0d", i + 1), 32'(dut.bright_q[2]), blink_exp[i]);
    end
    measure(1'b0, 1, n);
    check("blink_ch1", n, 15);
    measure(1'b0, 0, n);
    check("blink_ch0", n, 0);
    measure(1'b0, 3, n);
    check("blink_ch3", n, 0);

    // Out-of-range channel writes on the 5-channel instance
    wr5(3'd7, 2'd1, 4'd15);
    wr5(3'd5, 2'd1, 4'd15);
    k = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (led5 !== 5'h1F) k++;
    end
    check("oob_ignored", k, 0);
    wr5(3'd4, 2'd1, 4'd15);
    measure(1'b1, 4, n);
    measure(1'b1, 4, n);
    check("ch4_static", n, 15);

    // Brightness transfer function
    wr(2'd1, 2'd1, 4'd8);
    measure(1'b0, 1, n);
    measure(1'b0, 1, n);
    check("eff_8", n, G8);
    wr(2'd1, 2'd1, 4'd3);
    measure(1'b0, 1, n);
    measure(1'b0, 1, n);
    check("eff_3", n, G3);
    wr(2'd1, 2'd1, 4'd15);
    measure(1'b0, 1, n);
    measure(1'b0, 1, n);
    check("eff_15", n, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
